// File: rtl/spmmio_ledctl_if.sv
// rtl/spmmio_ledctl_if.sv - SP MMIO register bus bundle for the LED controller
interface spmmio_ledctl_if;
    logic [0:4]  adr;
    logic        cs;
    logic [0:3]  sel;
    logic        we;
    logic [0:31] d;
    logic [0:31] q;

    modport master (output adr, cs, sel, we, d, input q);
    modport slave  (input adr, cs, sel, we, d, output q);
endinterface

// File: rtl/spmmio_ledctl.sv
// rtl/spmmio_ledctl.sv - RGB LED override/default selector with blink timebase and PWM
module spmmio_ledctl #(
    parameter int NUM_LEDS     = 4,
    parameter int NUM_FLAGS    = 4,
    parameter int PWM_PRESCALE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    spmmio_ledctl_if.slave          bus,
    input  logic [0:NUM_FLAGS-1]    flags,
    input  logic [0:NUM_LEDS*24-1]  led_default,
    output logic [0:NUM_LEDS*24-1]  led_rgb,
    output logic [0:NUM_LEDS*3-1]   led_pwm
);
    localparam int PS_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PWM_PRESCALE - 1);

    logic [PS_W-1:0]      presc;
    logic                 tick;
    logic                 wrap;
    logic [7:0]           pwm_cnt;
    logic [15:0]          blink_half;
    logic [15:0]          blink_cnt;
    logic                 blink_phase;
    logic                 wr;
    logic                 blink_wr;
    logic [NUM_LEDS-1:0]  led_hit;
    logic [NUM_LEDS-1:0]  force_on;
    logic [NUM_LEDS-1:0]  blink_en;
    logic [0:23]          color   [NUM_LEDS];
    logic [0:NUM_FLAGS-1] mask    [NUM_LEDS];
    logic [0:23]          sel_col [NUM_LEDS];

    assign wr       = bus.cs && bus.we;
    assign tick     = (presc == PS_MAX);
    assign wrap     = tick && (pwm_cnt == 8'hFF);
    assign blink_wr = wr && (bus.adr == 5'h01) && (|bus.sel);

    // LED register pairs start at 0x10; adr[1:3] picks the LED, adr[4] picks COLOR/CTRL
    always_comb begin
        led_hit = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            led_hit[i] = bus.adr[0] && (bus.adr[1:3] == 3'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= '0;
            pwm_cnt     <= 8'd0;
            blink_cnt   <= 16'd0;
            blink_phase <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + PS_W'(1);
            if (tick)
                pwm_cnt <= pwm_cnt + 8'd1;
            // A BLINK write restarts the period even if a toggle was due this cycle
            if (blink_wr || blink_half == 16'd0) begin
                blink_cnt   <= 16'd0;
                blink_phase <= 1'b1;
            end else if (wrap) begin
                if (blink_cnt == blink_half - 16'd1) begin
                    blink_cnt   <= 16'd0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_half <= 16'd0;
            force_on   <= '0;
            blink_en   <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                color[i] <= '0;
                mask[i]  <= '0;
            end
        end else begin
            if (wr && bus.adr == 5'h01) begin
                if (bus.sel[2]) blink_half[15:8] <= bus.d[16:23];
                if (bus.sel[3]) blink_half[7:0]  <= bus.d[24:31];
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr && led_hit[i]) begin
                    if (!bus.adr[4]) begin
                        for (int b = 1; b < 4; b++)
                            if (bus.sel[b]) color[i][8*(b-1) +: 8] <= bus.d[8*b +: 8];
                    end else begin
                        if (bus.sel[0]) mask[i] <= bus.d[0 +: NUM_FLAGS];
                        if (bus.sel[1]) begin
                            force_on[i] <= bus.d[8];
                            blink_en[i] <= bus.d[9];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            sel_col[i] = led_default[24*i +: 24];
            if (force_on[i] || (|(mask[i] & flags)))
                sel_col[i] = (blink_en[i] && !blink_phase) ? 24'h0 : color[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_rgb <= '0;
            led_pwm <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_rgb[24*i +: 24] <= sel_col[i];
                for (int c = 0; c < 3; c++)
                    led_pwm[3*i + c] <= (sel_col[i][8*c +: 8] > pwm_cnt);
            end
        end
    end

    always_comb begin
        bus.q = '0;
        if (bus.adr == 5'h00) begin
            bus.q[0 +: NUM_FLAGS] = flags;
            bus.q[16:23]          = pwm_cnt;
            bus.q[31]             = blink_phase;
        end else if (bus.adr == 5'h01) begin
            bus.q[16:31] = blink_half;
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (led_hit[i]) begin
                if (!bus.adr[4]) begin
                    bus.q[8:31] = color[i];
                end else begin
                    bus.q[0 +: NUM_FLAGS] = mask[i];
                    bus.q[8]              = force_on[i];
                    bus.q[9]              = blink_en[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_spmmio_ledctl.sv
// tb/tb_spmmio_ledctl.sv - self-checking bench for spmmio_ledctl against a timeline model
module tb_spmmio_ledctl;
    localparam int NL = 4;
    localparam int NF = 4;
    localparam int P  = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spmmio_ledctl_if bus();
    logic [0:NF-1]    flags;
    logic [0:NL*24-1] led_default;
    logic [0:NL*24-1] led_rgb;
    logic [0:NL*3-1]  led_pwm;

    spmmio_ledctl #(.NUM_LEDS(NL), .NUM_FLAGS(NF), .PWM_PRESCALE(P)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .flags(flags),
        .led_default(led_default), .led_rgb(led_rgb), .led_pwm(led_pwm)
    );

    // Register shadow plus a cycle count; timebase values are derived from elapsed edges
    logic [0:23]   m_color [NL];
    logic [0:NF-1] m_mask  [NL];
    logic          m_force [NL];
    logic          m_ben   [NL];
    logic [15:0]   m_blink;
    int            n, wb;
    int            checks, errors;
    logic [0:NL*24-1] exp_rgb;
    logic [0:NL*3-1]  exp_pwm;

    function automatic int pwm_at(int k);
        return (k / P) % 256;
    endfunction

    function automatic logic phase_at(int k);
        int w;
        if (m_blink == 16'd0) return 1'b1;
        w = k / (256 * P) - wb / (256 * P);
        return ((w / int'(m_blink)) % 2) == 0;
    endfunction

    function automatic logic [0:23] m_sel(int i);
        if (!(m_force[i] || (|(m_mask[i] & flags)))) return led_default[24*i +: 24];
        if (m_ben[i] && !phase_at(n)) return 24'h0;
        return m_color[i];
    endfunction

    function automatic logic [0:31] m_read(int a);
        logic [0:31] r;
        int i;
        r = '0;
        if (a == 0) begin
            r[0 +: NF] = flags;
            r[16:23]   = 8'(pwm_at(n));
            r[31]      = phase_at(n);
        end else if (a == 1) begin
            r[16:31] = m_blink;
        end else if (a >= 16 && (a - 16) / 2 < NL) begin
            i = (a - 16) / 2;
            if (a % 2 == 0) r[8:31] = m_color[i];
            else begin
                r[0 +: NF] = m_mask[i];
                r[8]       = m_force[i];
                r[9]       = m_ben[i];
            end
        end
        return r;
    endfunction

    task automatic model_write(int a, logic [0:3] s, logic [0:31] dd, int e);
        int i;
        if (a == 1) begin
            if (s[2]) m_blink[15:8] = dd[16:23];
            if (s[3]) m_blink[7:0]  = dd[24:31];
            if (|s) wb = e;
        end else if (a >= 16 && (a - 16) / 2 < NL) begin
            i = (a - 16) / 2;
            if (a % 2 == 0) begin
                if (s[1]) m_color[i][0:7]   = dd[8:15];
                if (s[2]) m_color[i][8:15]  = dd[16:23];
                if (s[3]) m_color[i][16:23] = dd[24:31];
            end else begin
                if (s[0]) m_mask[i] = dd[0 +: NF];
                if (s[1]) begin
                    m_force[i] = dd[8];
                    m_ben[i]   = dd[9];
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [95:0] obs, logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(bit do_chk);
        logic [0:23] s;
        for (int i = 0; i < NL; i++) begin
            s = m_sel(i);
            exp_rgb[24*i +: 24] = s;
            for (int c = 0; c < 3; c++)
                exp_pwm[3*i + c] = (int'(s[8*c +: 8]) > pwm_at(n));
        end
        if (!reset && bus.cs && bus.we) model_write(int'(bus.adr), bus.sel, bus.d, n + 1);
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < NL; i++) begin
                m_color[i] = '0; m_mask[i] = '0; m_force[i] = 1'b0; m_ben[i] = 1'b0;
            end
            m_blink = 16'd0; n = 0; wb = 0;
        end else begin
            n++;
        end
        if (do_chk) begin
            chk("led_rgb", 96'(led_rgb), 96'(exp_rgb));
            chk("led_pwm", 96'(led_pwm), 96'(exp_pwm));
        end
    endtask

    task automatic wr(int a, logic [0:3] s, logic [0:31] dd);
        bus.adr = 5'(a); bus.sel = s; bus.d = dd; bus.cs = 1'b1; bus.we = 1'b1;
        step(1);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd_chk(int a);
        bus.adr = 5'(a);
        #1;
        chk($sformatf("read_%02h", a), 96'(bus.q), 96'(m_read(a)));
        step(1);
    endtask

    int cnt_r, cnt_g, cnt_b;
    int act;

    initial begin
        checks = 0; errors = 0; n = 0; wb = 0; m_blink = 16'd0;
        for (int i = 0; i < NL; i++) begin
            m_color[i] = '0; m_mask[i] = '0; m_force[i] = 1'b0; m_ben[i] = 1'b0;
        end
        bus.adr = '0; bus.cs = 1'b0; bus.sel = '0; bus.we = 1'b0; bus.d = '0;
        flags = '0;
        led_default = {24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h405060};
        reset = 1'b1;
        repeat (3) step(0);
        reset = 1'b0;
        step(1);
        chk("rst_led0", 96'(led_rgb[0:23]), 96'(24'hFF0000));
        bus.adr = 5'h00; #1;
        chk("rst_phase", 96'(bus.q[31]), 96'(1'b1));
        for (int a = 0; a < 32; a++) rd_chk(a);

        // Override via flag mask on LED 1
        wr(5'h12, 4'b0111, 32'h00123456);
        wr(5'h13, 4'b1000, 32'h80000000);
        flags = 4'b1000;
        step(1);
        chk("ovr_on", 96'(led_rgb[24:47]), 96'(24'h123456));
        flags = 4'b0000;
        step(1);
        chk("ovr_off", 96'(led_rgb[24:47]), 96'(24'h00FF00));

        // Byte-enable merge and unimplemented mask bits
        wr(5'h12, 4'b0001, 32'h000000AA);
        bus.adr = 5'h12; #1;
        chk("color_merge", 96'(bus.q), 96'(32'h001234AA));
        step(1);
        wr(5'h13, 4'b1111, 32'h08000000);
        bus.adr = 5'h13; #1;
        chk("mask_hi_bits", 96'(bus.q), 96'(32'h0));
        step(1);

        // PWM duty over one full period on forced LED 2
        wr(5'h14, 4'b0111, 32'h0080FF00);
        wr(5'h15, 4'b0100, 32'h00800000);
        cnt_r = 0; cnt_g = 0; cnt_b = 0;
        for (int k = 0; k < 256; k++) begin
            step(1);
            cnt_r += int'(led_pwm[6]);
            cnt_g += int'(led_pwm[7]);
            cnt_b += int'(led_pwm[8]);
        end
        chk("pwm_r", 96'(cnt_r), 96'(128));
        chk("pwm_g", 96'(cnt_g), 96'(255));
        chk("pwm_b", 96'(cnt_b), 96'(0));

        // Blink with half-period of two PWM periods, then restart mid-period
        wr(5'h01, 4'b0011, 32'h00000002);
        wr(5'h15, 4'b0100, 32'h00C00000);
        repeat (1100) step(1);
        chk("blink_dark", 96'(led_rgb[48:71]), 96'(m_sel(2)));
        repeat (150) step(1);
        wr(5'h01, 4'b0001, 32'h00000002);
        bus.adr = 5'h00; #1;
        chk("blink_restart", 96'(bus.q[31]), 96'(1'b1));
        step(1);
        repeat (600) step(1);
        rd_chk(5'h00);

        // Unmapped addresses stay zero and ignore writes
        wr(5'h18, 4'b1111, 32'hFFFFFFFF);
        wr(5'h02, 4'b1111, 32'hFFFFFFFF);
        wr(5'h1F, 4'b1111, 32'hFFFFFFFF);
        bus.adr = 5'h18; #1;
        chk("unmapped_18", 96'(bus.q), 96'(32'h0));
        step(1);
        for (int a = 0; a < 32; a++) rd_chk(a);

        // Randomized mix of writes, flag/default changes and reads
        for (int k = 0; k < 400; k++) begin
            act = int'($urandom_range(0, 3));
            case (act)
                0: begin
                    int a;
                    a = int'($urandom_range(0, 31));
                    if (a == 1) wr(a, 4'b0011, $urandom_range(0, 3));
                    else wr(a, 4'($urandom_range(1, 15)), $urandom);
                end
                1: begin flags = NF'($urandom); step(1); end
                2: begin led_default = {$urandom, $urandom, $urandom}; step(1); end
                default: rd_chk(int'($urandom_range(0, 31)));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spmmio_ledctl.md
Name: spmmio_ledctl

Overview:
- Parametrised successor to the misc MMIO LED logic. Drives NUM_LEDS RGB LEDs.
- Each LED shows a programmable override colour or a caller-supplied default colour, depending on a per-LED flag mask and a force bit.
- Adds a global blink timebase and per-colour-component PWM outputs for direct pin drive.
- Sits on the SP MMIO bus beside the misc block. Uses the same big-endian bus conventions, with sel[k] qualifying d[8k:8k+7].

Parameters:
- NUM_LEDS, 4, number of RGB LED channels (1..8).
- NUM_FLAGS, 4, width of the activity flag input (1..8).
- PWM_PRESCALE, 4, clk cycles per PWM tick (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- adr  in  [0:4]  word address
- cs  in  1  chip select
- sel  in  [0:3]  byte enables, big-endian
- we  in  1  write enable (write when cs && we)
- d  in  [0:31]  write data
- q  out  [0:31]  read data, combinational from adr
- flags  in  [0:NUM_FLAGS-1]  activity flags (turbo, drive activity, ...)
- led_default  in  [0:NUM_LEDS*24-1]  default colour per LED; LED i at bits [24i:24i+23]
- led_rgb  out  [0:NUM_LEDS*24-1]  selected colour per LED, registered
- led_pwm  out  [0:NUM_LEDS*3-1]  PWM bit per LED for R,G,B, registered

Behaviour:
- Register map:
  - 0x00 STATUS (RO): q[0:7] = flags, left-aligned, zero-padded; q[16:23] = pwm_cnt; q[31] = blink_phase.
  - 0x01 BLINK (RW): q[16:31] = blink half-period, in PWM periods (256 ticks).
  - 0x10+2i COLOR_i (RW): q[8:31] = RGB, R in [8:15].
  - 0x11+2i CTRL_i (RW): [0:7] flag mask, bits >= NUM_FLAGS read 0 and ignore writes; [8] force; [9] blink_en.
  - All other addresses, and LEDs i >= NUM_LEDS: read 0, writes ignored.
- Writes take effect at the clock edge, per enabled byte only; unselected bytes are unchanged.
- Reset values: all COLOR, CTRL and BLINK = 0; prescaler = 0; pwm_cnt = 0; blink counter = 0; blink_phase = 1. Registered outputs take their first post-reset value one cycle after reset deasserts.
- Prescaler: counts 0..PWM_PRESCALE-1. tick is asserted when it wraps; PWM_PRESCALE=1 gives a tick every cycle.
- pwm_cnt: 8-bit, increments on tick, wraps 255 -> 0. wrap = tick && pwm_cnt == 255.
- Blink counter (16-bit):
  - On wrap, if BLINK != 0: counter increments; when counter == BLINK-1, counter clears and blink_phase toggles.
  - If BLINK == 0: counter stays 0 and blink_phase is held at 1.
  - Any write to BLINK (any byte) clears the counter and sets blink_phase = 1 in that cycle, overriding a simultaneous toggle.
- Per LED i, each cycle:
  - ovr_i = force_i | (|(mask_i & flags)).
  - sel_i = ovr_i ? (blink_en_i && !blink_phase ? 24'h0 : COLOR_i) : led_default_i.
  - led_rgb_i <= sel_i (1 cycle latency from any register or input change).
  - led_pwm_i[c] <= (sel_i component c > pwm_cnt):
    - component 0 -> never on; 255 -> on 255 of 256 ticks.
    - Uses the current pwm_cnt, so led_pwm lags sel by 1 cycle.
- A simultaneous bus write and flag change both appear in the same registered output cycle.
- reset has priority over bus writes.
- q is purely combinational from adr and registers and is independent of cs.

Test Plan:
- Reset, NUM_LEDS=4, led_default_0=0xFF0000, flags=0 -> after 1 cycle led_rgb_0=0xFF0000; all registers read 0 except STATUS[31]=1.
- Write COLOR_1 (adr 0x12) with d=0x00123456 using sel=0111, then CTRL_1 mask=0x80; assert flags[0] -> led_rgb_1=0x123456 one cycle later; deassert flags[0] -> default returns one cycle later.
- Write COLOR_1 with sel=0001, d=0x000000AA, prior value 0x123456 -> reads 0x001234AA; write CTRL_1 with d[4]=1, NUM_FLAGS=4 -> reads back 0.
- PWM_PRESCALE=1, forced LED with COLOR=0x80FF00 -> over 256 cycles led_pwm R high exactly 128 cycles, G 255, B 0.
- BLINK=2, force + blink_en, PWM_PRESCALE=1 -> blink_phase toggles every 512 cycles, led_rgb alternates COLOR/0; rewriting BLINK mid-period restarts with phase=1.
- Reads of adr 0x18+ (NUM_LEDS=4), 0x02 and 0x1F return 0; writes there change no readable state.
